add_operand_recover: RTL and testbench

- Sequential inverse of the team's 4-bit adder function.
- Given a (WIDTH+1)-bit sum and one WIDTH-bit addend `a`, it recovers the other addend: b = sum - a.
- Works bit-serially, LSB first, through a single 1-bit full subtractor and a borrow flop.
- Uses a start/busy/done handshake and sits beside the adder datapath as its checker/decoder.

---
 rtl/add_recover_pkg.sv | 12 +
 rtl/full_sub_bit.sv | 20 ++
 rtl/add_operand_recover.sv | 155 +++++++++++++++
 tb/tb_add_operand_recover.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/add_recover_pkg.sv
// Shared definitions for the add_operand_recover block.
// Holds the FSM state encoding and the default addend width.
// The encoding 2'd3 is unused and is treated as IDLE by the FSM.
package add_recover_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/full_sub_bit.sv
// One-bit full subtractor: computes x - y - bin.
// Ports:
//   x    - minuend bit
//   y    - subtrahend bit
//   bin  - borrow in
//   d    - difference bit
//   bout - borrow out
module full_sub_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // A borrow is needed when y exceeds x, or when x equals y and a borrow is pending.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/add_operand_recover.sv
// Bit-serial recovery of an adder operand: b = sum - a.
// The subtraction runs LSB first through one full_sub_bit and a borrow flop,
// taking WIDTH+1 steps, and is framed by a start/busy/done handshake.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   start - request, accepted only in IDLE
//   sum   - WIDTH+1 bit minuend, sampled on the accept edge
//   a     - WIDTH bit known addend, sampled on the accept edge
//   busy  - high in RUN and DONE
//   done  - one-cycle pulse when b and err are updated
//   b     - recovered addend (low WIDTH bits of the difference)
//   err   - high when the result does not fit in WIDTH bits
module add_operand_recover
  import add_recover_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH:0]   sum,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] b,
  output logic             err
);

  // Counter must hold values 0..WIDTH.
  localparam int CW = $clog2(WIDTH + 2);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic             busy_next;
  logic             done_next;

  logic [WIDTH:0]   x_sr;
  logic [WIDTH:0]   y_sr;
  // Holds the low WIDTH difference bits; the final (MSB) bit is consumed
  // directly from the subtractor on the last step.
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             borrow;

  logic             bit_d;
  logic             bit_bout;
  logic             last_step;

  full_sub_bit u_full_sub_bit (
    .x    (x_sr[0]),
    .y    (y_sr[0]),
    .bin  (borrow),
    .d    (bit_d),
    .bout (bit_bout)
  );

  assign last_step = (cnt == CW'(WIDTH));

  // State register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Next-state decode; the unused encoding falls back to IDLE.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (last_step) begin
          next_state = DONE;
        end else begin
          next_state = RUN;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the next state so busy/done can be registered.
  always_comb begin
    busy_next = 1'b0;
    done_next = 1'b0;
    case (next_state)
      RUN: begin
        busy_next = 1'b1;
        done_next = 1'b0;
      end
      DONE: begin
        busy_next = 1'b1;
        done_next = 1'b1;
      end
      default: begin
        busy_next = 1'b0;
        done_next = 1'b0;
      end
    endcase
  end

  // Serial datapath: operand load, one subtract step per RUN cycle, result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_sr   <= '0;
      y_sr   <= '0;
      res    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      b      <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_sr   <= sum;
            y_sr   <= {1'b0, a};
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          x_sr   <= {1'b0, x_sr[WIDTH:1]};
          y_sr   <= {1'b0, y_sr[WIDTH:1]};
          borrow <= bit_bout;
          res    <= {bit_d, res[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            // res already holds diff[WIDTH-1:0]; bit_d is diff[WIDTH].
            b   <= res;
            err <= bit_bout | bit_d;
          end
        end
        default: begin
          // DONE and unused states leave the datapath untouched.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_operand_recover.sv
// Self-checking bench for add_operand_recover (WIDTH=4) plus a standalone
// exhaustive check of full_sub_bit. Stimulus pushes expected results into a
// queue; a monitor pops and compares on every done pulse.
module tb_add_operand_recover;

  typedef struct {
    logic [3:0] b;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] sum;
  logic [3:0] a;
  logic       busy;
  logic       done;
  logic [3:0] b;
  logic       err;

  logic fx, fy, fb, fd, fbo;

  int   pass_cnt;
  int   total_cnt;
  int   done_cnt;
  int   cyc;
  int   done_cyc;
  exp_t exp_q[$];

  add_operand_recover #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sum   (sum),
    .a     (a),
    .busy  (busy),
    .done  (done),
    .b     (b),
    .err   (err)
  );

  full_sub_bit u_fsb (
    .x    (fx),
    .y    (fy),
    .bin  (fb),
    .d    (fd),
    .bout (fbo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used for throughput measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_b", {28'd0, b}, {28'd0, e.b});
        check("result_err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  // One isolated operation with latency, busy and hold checks.
  task automatic run_op(input logic [4:0] s, input logic [3:0] x, input logic [3:0] eb,
                        input logic ee, input logic [3:0] prev_b);
    int lat;
    @(posedge clk);
    #1;
    sum = s;
    a = x;
    start = 1'b1;
    exp_q.push_back('{b: eb, err: ee});
    @(posedge clk);
    #1;
    start = 1'b0;
    sum = 5'd0;
    a = 4'd0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("b_holds_on_accept", {28'd0, b}, {28'd0, prev_b});
    wait_done(lat);
    check("latency", lat, 32'd5);
    check("busy_in_done", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_back_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int d0;
    int t1;
    pass_cnt  = 0;
    total_cnt = 0;
    done_cnt  = 0;
    cyc       = 0;
    done_cyc  = 0;
    rst   = 1'b1;
    start = 1'b0;
    sum   = 5'd0;
    a     = 4'd0;
    fx = 1'b0; fy = 1'b0; fb = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_b", {28'd0, b}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);

    // Full subtractor truth table from integer arithmetic x - y - bin.
    for (int i = 0; i < 8; i++) begin
      int xi, yi, bi, df;
      xi = (i >> 2) & 1;
      yi = (i >> 1) & 1;
      bi = i & 1;
      fx = xi[0]; fy = yi[0]; fb = bi[0];
      #1;
      df = xi - yi - bi;
      check("fsb_d", {31'd0, fd}, (df & 1));
      check("fsb_bout", {31'd0, fbo}, (df < 0) ? 32'd1 : 32'd0);
    end

    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(5'd9,  4'd3,  4'd6,  1'b0, 4'd0);   // 9-3 = 6
    run_op(5'd31, 4'd15, 4'd0,  1'b1, 4'd6);   // 16: MSB set
    run_op(5'd2,  4'd5,  4'd13, 1'b1, 4'd0);   // -3 -> 29

    // Back-to-back with start held high throughout.
    d0 = done_cnt;
    @(posedge clk);
    #1;
    sum = 5'd0;
    a = 4'd0;
    start = 1'b1;
    exp_q.push_back('{b: 4'd0, err: 1'b0});
    exp_q.push_back('{b: 4'd15, err: 1'b0});
    @(posedge clk);
    #1;
    sum = 5'd30;
    a = 4'd15;
    wait_done(lat);
    check("b2b_first_latency", lat, 32'd5);
    t1 = cyc;
    @(posedge clk);
    #1;
    check("b2b_idle_busy", {31'd0, busy}, 32'd0);
    wait_done(lat);
    start = 1'b0;
    check("b2b_throughput", cyc - t1, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    check("b2b_done_count", done_cnt - d0, 32'd2);

    // Start during RUN is ignored.
    d0 = done_cnt;
    @(posedge clk);
    #1;
    sum = 5'd9;
    a = 4'd3;
    start = 1'b1;
    exp_q.push_back('{b: 4'd6, err: 1'b0});
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    sum = 5'd20;
    a = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check("ignore_latency", lat, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    check("ignore_done_count", done_cnt - d0, 32'd1);

    // Reset mid-operation aborts with no done pulse.
    d0 = done_cnt;
    @(posedge clk);
    #1;
    sum = 5'd9;
    a = 4'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_b", {28'd0, b}, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 32'd0);

    run_op(5'd9, 4'd3, 4'd6, 1'b0, 4'd0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
